// File: rtl/ex_alu_rs.sv
// ALU reservation station: holds issued ALU/branch ops, wakes operands from the CDB,
// selects one ready entry per cycle and registers its result and redirect.
module ex_alu_rs #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  parameter int TAG_W = 4,
  parameter int OP_W  = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdy,
  input  logic                         flush,
  input  logic                         issue_valid,
  output logic                         issue_ready,
  input  logic [OP_W-1:0]              issue_op,
  input  logic [XLEN-1:0]              issue_pc,
  input  logic [TAG_W-1:0]             issue_tagx,
  input  logic [TAG_W-1:0]             issue_tagy,
  input  logic [XLEN-1:0]              issue_datax,
  input  logic [XLEN-1:0]              issue_datay,
  input  logic [XLEN-1:0]              issue_imm,
  input  logic [TAG_W-1:0]             issue_tagw,
  input  logic [4:0]                   issue_target,
  input  logic                         cdb_valid,
  input  logic [TAG_W-1:0]             cdb_tag,
  input  logic [XLEN-1:0]              cdb_data,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic                         res_we,
  output logic [4:0]                   res_target,
  output logic [TAG_W-1:0]             res_tag,
  output logic [XLEN-1:0]              res_data,
  output logic                         jmp_en,
  output logic [XLEN-1:0]              jmp_addr,
  output logic [$clog2(DEPTH+1)-1:0]   busy_cnt
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int SH_W  = $clog2(XLEN);

  localparam logic [OP_W-1:0] OP_ADD = 6'd0,  OP_SUB = 6'd1,  OP_SLL = 6'd2,  OP_SLT = 6'd3,
                              OP_SLTU = 6'd4, OP_XOR = 6'd5,  OP_SRL = 6'd6,  OP_SRA = 6'd7,
                              OP_OR = 6'd8,   OP_AND = 6'd9,  OP_LUI = 6'd10, OP_AUIPC = 6'd11,
                              OP_JAL = 6'd12, OP_JALR = 6'd13, OP_BEQ = 6'd14, OP_BNE = 6'd15,
                              OP_BLT = 6'd16, OP_BGE = 6'd17, OP_BLTU = 6'd18, OP_BGEU = 6'd19;

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [OP_W-1:0]  op_q    [DEPTH], op_d    [DEPTH];
  logic [XLEN-1:0]  pc_q    [DEPTH], pc_d    [DEPTH];
  logic [TAG_W-1:0] tagx_q  [DEPTH], tagx_d  [DEPTH];
  logic [TAG_W-1:0] tagy_q  [DEPTH], tagy_d  [DEPTH];
  logic [XLEN-1:0]  datax_q [DEPTH], datax_d [DEPTH];
  logic [XLEN-1:0]  datay_q [DEPTH], datay_d [DEPTH];
  logic [XLEN-1:0]  imm_q   [DEPTH], imm_d   [DEPTH];
  logic [TAG_W-1:0] tagw_q  [DEPTH], tagw_d  [DEPTH];
  logic [4:0]       tgt_q   [DEPTH], tgt_d   [DEPTH];

  logic [CNT_W-1:0] busy_q, busy_d;
  logic             res_valid_q, res_valid_d, res_we_q, res_we_d, jmp_en_q, jmp_en_d;
  logic [4:0]       res_target_q, res_target_d;
  logic [TAG_W-1:0] res_tag_q, res_tag_d;
  logic [XLEN-1:0]  res_data_q, res_data_d, jmp_addr_q, jmp_addr_d;

  logic             sel_hit, free_hit, do_sel, accept;
  logic [IDX_W-1:0] sel_idx, free_idx;
  logic [XLEN-1:0]  ax, ay, apc, alu_data, alu_jaddr;
  logic             alu_we, alu_jen, taken;
  logic [SH_W-1:0]  shamt;

  assign issue_ready = (busy_q != CNT_W'(DEPTH));
  assign accept      = issue_valid && issue_ready && free_hit;

  always_comb begin
    vld_d = vld_q;   op_d = op_q;     pc_d = pc_q;     tagx_d = tagx_q; tagy_d = tagy_q;
    datax_d = datax_q; datay_d = datay_q; imm_d = imm_q; tagw_d = tagw_q; tgt_d = tgt_q;
    sel_hit = 1'b0;  sel_idx = '0;    free_hit = 1'b0; free_idx = '0;

    for (int i = 0; i < DEPTH; i++) begin
      if (!sel_hit && vld_q[i] && tagx_q[i] == '0 && tagy_q[i] == '0) begin
        sel_hit = 1'b1;
        sel_idx = IDX_W'(i);
      end
      if (!free_hit && !vld_q[i]) begin
        free_hit = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
    do_sel = sel_hit && (!res_valid_q || res_ready);

    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && cdb_valid && cdb_tag != '0) begin
        if (tagx_q[i] == cdb_tag) begin tagx_d[i] = '0; datax_d[i] = cdb_data; end
        if (tagy_q[i] == cdb_tag) begin tagy_d[i] = '0; datay_d[i] = cdb_data; end
      end
    end

    if (do_sel) vld_d[sel_idx] = 1'b0;

    // Issue slot is always free in the registered state, so it never collides with select.
    if (accept) begin
      vld_d[free_idx]   = 1'b1;
      op_d[free_idx]    = issue_op;
      pc_d[free_idx]    = issue_pc;
      imm_d[free_idx]   = issue_imm;
      tagw_d[free_idx]  = issue_tagw;
      tgt_d[free_idx]   = issue_target;
      tagx_d[free_idx]  = issue_tagx;
      datax_d[free_idx] = issue_datax;
      tagy_d[free_idx]  = issue_tagy;
      datay_d[free_idx] = issue_datay;
      if (cdb_valid && issue_tagx != '0 && issue_tagx == cdb_tag) begin
        tagx_d[free_idx] = '0; datax_d[free_idx] = cdb_data;
      end
      if (cdb_valid && issue_tagy != '0 && issue_tagy == cdb_tag) begin
        tagy_d[free_idx] = '0; datay_d[free_idx] = cdb_data;
      end
    end

    ax = datax_q[sel_idx];
    ay = datay_q[sel_idx];
    apc = pc_q[sel_idx];
    shamt = ay[SH_W-1:0];
    alu_data = '0; alu_jaddr = '0; alu_we = 1'b1; alu_jen = 1'b0; taken = 1'b0;
    case (op_q[sel_idx])
      OP_ADD:   alu_data = ax + ay;
      OP_SUB:   alu_data = ax - ay;
      OP_SLL:   alu_data = ax << shamt;
      OP_SLT:   alu_data = XLEN'($signed(ax) < $signed(ay));
      OP_SLTU:  alu_data = XLEN'(ax < ay);
      OP_XOR:   alu_data = ax ^ ay;
      OP_SRL:   alu_data = ax >> shamt;
      OP_SRA:   alu_data = XLEN'($signed(ax) >>> shamt);
      OP_OR:    alu_data = ax | ay;
      OP_AND:   alu_data = ax & ay;
      OP_LUI:   alu_data = ax;
      OP_AUIPC: alu_data = ax + apc;
      OP_JAL:   begin alu_data = apc + XLEN'(4); alu_jen = 1'b1; alu_jaddr = apc + ax; end
      OP_JALR:  begin alu_data = apc + XLEN'(4); alu_jen = 1'b1; alu_jaddr = (ax + ay) & ~XLEN'(1); end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        alu_we = 1'b0;
        case (op_q[sel_idx])
          OP_BEQ:  taken = (ax == ay);
          OP_BNE:  taken = (ax != ay);
          OP_BLT:  taken = ($signed(ax) < $signed(ay));
          OP_BGE:  taken = ($signed(ax) >= $signed(ay));
          OP_BLTU: taken = (ax < ay);
          default: taken = (ax >= ay);
        endcase
        alu_jen = taken;
        alu_jaddr = taken ? apc + imm_q[sel_idx] : '0;
      end
      default:  alu_we = 1'b0;
    endcase

    res_valid_d = res_valid_q; res_we_d = res_we_q; jmp_en_d = jmp_en_q;
    res_target_d = res_target_q; res_tag_d = res_tag_q; res_data_d = res_data_q;
    jmp_addr_d = jmp_addr_q;
    if (do_sel) begin
      res_valid_d  = 1'b1;
      res_we_d     = alu_we && (tgt_q[sel_idx] != 5'd0);
      res_target_d = tgt_q[sel_idx];
      res_tag_d    = tagw_q[sel_idx];
      res_data_d   = alu_data;
      jmp_en_d     = alu_jen;
      jmp_addr_d   = alu_jaddr;
    end else if (res_ready) begin
      res_valid_d = 1'b0; res_we_d = 1'b0; jmp_en_d = 1'b0;
    end

    busy_d = busy_q + CNT_W'(accept) - CNT_W'(do_sel);

    if (flush) begin
      vld_d = '0; busy_d = '0; res_valid_d = 1'b0; res_we_d = 1'b0; jmp_en_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0; busy_q <= '0;
      res_valid_q <= 1'b0; res_we_q <= 1'b0; jmp_en_q <= 1'b0;
      res_target_q <= '0; res_tag_q <= '0; res_data_q <= '0; jmp_addr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i] <= '0; pc_q[i] <= '0; tagx_q[i] <= '0; tagy_q[i] <= '0; datax_q[i] <= '0;
        datay_q[i] <= '0; imm_q[i] <= '0; tagw_q[i] <= '0; tgt_q[i] <= '0;
      end
    end else if (rdy) begin
      vld_q <= vld_d; busy_q <= busy_d;
      op_q <= op_d; pc_q <= pc_d; tagx_q <= tagx_d; tagy_q <= tagy_d; datax_q <= datax_d;
      datay_q <= datay_d; imm_q <= imm_d; tagw_q <= tagw_d; tgt_q <= tgt_d;
      res_valid_q <= res_valid_d; res_we_q <= res_we_d; jmp_en_q <= jmp_en_d;
      res_target_q <= res_target_d; res_tag_q <= res_tag_d; res_data_q <= res_data_d;
      jmp_addr_q <= jmp_addr_d;
    end
  end

  assign res_valid  = res_valid_q;
  assign res_we     = res_we_q;
  assign res_target = res_target_q;
  assign res_tag    = res_tag_q;
  assign res_data   = res_data_q;
  assign jmp_en     = jmp_en_q;
  assign jmp_addr   = jmp_addr_q;
  assign busy_cnt   = busy_q;
endmodule
